// File: rtl/ctrl_pkg.sv
// Shared control-unit definitions: RV32I opcodes, one-hot type-code bit positions, decode entry.
// Consumed by the decode stage and the downstream selector modules so both agree on encoding.
package ctrl_pkg;

  localparam int XLEN   = 32;
  localparam int CODE_W = 10;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int CODE_J     = 0;
  localparam int CODE_JALR  = 1;
  localparam int CODE_LUI   = 2;
  localparam int CODE_AUIPC = 3;
  localparam int CODE_B     = 4;
  localparam int CODE_R     = 5;
  localparam int CODE_S     = 6;
  localparam int CODE_I     = 7;
  localparam int CODE_LOAD  = 8;
  localparam int CODE_CSR   = 9;

  typedef logic [CODE_W-1:0] code_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    code_t           code;
    logic            illegal;
  } entry_t;

  function automatic code_t code_bit(input int idx);
    code_t c;
    c      = '0;
    c[idx] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/instr_type_decode_stage_if.sv
// Fetch-to-selector handshake bundle for the decode stage: input stream, output stream and flush.
// master = environment side (fetch + consumer), slave = the decode stage itself.
interface instr_type_decode_stage_if;
  import ctrl_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic            out_valid;
  logic            out_ready;
  code_t           out_code;
  logic [XLEN-1:0] out_instr;
  logic            out_illegal;
  logic            flush;

  modport master (
    output in_valid, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_code, out_instr, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, out_ready, flush,
    output in_ready, out_valid, out_code, out_instr, out_illegal
  );

endinterface

// File: rtl/instr_type_decode_stage_onehot.sv
// Combinational opcode classifier: opcode -> one-hot type code, illegal flag; 0 cycles, no handshake.
// Unknown opcodes (FENCE included) or a non-32-bit encoding give code=0, illegal=1.
module instr_type_onehot
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output code_t      code,
  output logic       illegal
);

  always_comb begin
    code = '0;
    case (opcode)
      OP_JAL:    code = code_bit(CODE_J);
      OP_JALR:   code = code_bit(CODE_JALR);
      OP_LUI:    code = code_bit(CODE_LUI);
      OP_AUIPC:  code = code_bit(CODE_AUIPC);
      OP_BRANCH: code = code_bit(CODE_B);
      OP_OP:     code = code_bit(CODE_R);
      OP_STORE:  code = code_bit(CODE_S);
      OP_OPIMM:  code = code_bit(CODE_I);
      OP_LOAD:   code = code_bit(CODE_LOAD);
      OP_SYSTEM: code = code_bit(CODE_CSR);
      default:   code = '0;
    endcase
    illegal = (opcode[1:0] != 2'b11) || (code == '0);
  end

endmodule

// File: rtl/instr_type_decode_stage.sv
// Registered decode stage: classifies fetched instructions, 1-cycle latency, main+skid entries.
// Backpressure: in_ready = ~skid_full from state only, so fetch never sees out_ready combinationally.
module instr_type_decode_stage
  import ctrl_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  instr_type_decode_stage_if.slave    bus
);

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_vld_q, main_vld_d;
  logic   skid_vld_q, skid_vld_d;

  code_t  dec_code;
  logic   dec_illegal;
  entry_t dec_entry;
  logic   accept;
  logic   pop;

  instr_type_onehot u_onehot (
    .opcode  (bus.in_instr[6:0]),
    .code    (dec_code),
    .illegal (dec_illegal)
  );

  assign dec_entry = '{instr: bus.in_instr, code: dec_code, illegal: dec_illegal};

  // Capture only on accept so an X word offered with in_valid low never reaches the flops.
  assign accept = bus.in_valid & ~skid_vld_q;
  assign pop    = main_vld_q & bus.out_ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (bus.flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      if (pop) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (main_vld_q) begin
      case ({accept, pop})
        2'b10: begin
          skid_d     = dec_entry;
          skid_vld_d = 1'b1;
        end
        2'b11:   main_d     = dec_entry;
        2'b01:   main_vld_d = 1'b0;
        default: main_vld_d = main_vld_q;
      endcase
    end else if (accept) begin
      main_d     = dec_entry;
      main_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign bus.in_ready    = ~skid_vld_q;
  assign bus.out_valid   = main_vld_q;
  assign bus.out_code    = main_q.code;
  assign bus.out_instr   = main_q.instr;
  assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_instr_type_decode_stage.sv
// Bench for instr_type_decode_stage: directed scenarios then random traffic against a queue model.
module tb_instr_type_decode_stage;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  instr_type_decode_stage_if bus ();

  instr_type_decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] q[$];
  logic [6:0]  opc_tab[10] = '{7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1100011,
                               7'b0110011, 7'b0100011, 7'b0010011, 7'b0000011, 7'b1110011};
  logic [31:0] rnd;
  logic [31:0] word;
  logic        rv, rr, rf;

  // Reference classifier: position of the opcode in the table gives the one-hot bit.
  function automatic logic [9:0] ref_code(input logic [31:0] w);
    logic [9:0] c;
    c = '0;
    for (int i = 0; i < 10; i++)
      if (w[6:0] == opc_tab[i]) c[i] = 1'b1;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("in_ready", {31'b0, bus.in_ready}, {31'b0, q.size() < 2});
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, q.size() != 0});
    if (q.size() != 0) begin
      chk("out_instr", bus.out_instr, q[0]);
      chk("out_code", {22'b0, bus.out_code}, {22'b0, ref_code(q[0])});
      chk("out_illegal", {31'b0, bus.out_illegal}, {31'b0, ref_code(q[0]) == 10'b0});
    end
  endtask

  // One clock: check state, drive inputs at the falling edge, advance model at the rising edge.
  task automatic cyc(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
    logic acc, pp;
    check_outputs();
    bus.in_valid  = v;
    bus.in_instr  = v ? w : 32'hxxxx_xxxx;
    bus.out_ready = ordy;
    bus.flush     = fl;
    acc = v && (q.size() < 2) && !fl;
    pp  = ordy && (q.size() > 0) && !fl;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(w);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_code", {22'b0, bus.out_code}, 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_out_illegal", {31'b0, bus.out_illegal}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    rst_n = 1'b1;

    // jal x0,0
    cyc(1'b1, 32'h0000006F, 1'b1, 1'b0);
    chk("t1_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("t1_code", {22'b0, bus.out_code}, 32'b0000000001);
    chk("t1_illegal", {31'b0, bus.out_illegal}, 32'd0);

    // back-to-back stream
    cyc(1'b1, 32'h00500093, 1'b1, 1'b0);
    chk("t2_code_addi", {22'b0, bus.out_code}, 32'b0010000000);
    cyc(1'b1, 32'h000012B7, 1'b1, 1'b0);
    chk("t2_code_lui", {22'b0, bus.out_code}, 32'b0000000100);
    cyc(1'b1, 32'h00002083, 1'b1, 1'b0);
    chk("t2_code_lw", {22'b0, bus.out_code}, 32'b0100000000);
    chk("t2_in_ready", {31'b0, bus.in_ready}, 32'd1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // stall fills skid, then drain in order
    cyc(1'b1, 32'h00208033, 1'b0, 1'b0);
    cyc(1'b1, 32'h00112023, 1'b0, 1'b0);
    chk("t3_in_ready_full", {31'b0, bus.in_ready}, 32'd0);
    chk("t3_first_code", {22'b0, bus.out_code}, 32'b0000100000);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t3_second_code", {22'b0, bus.out_code}, 32'b0001000000);
    chk("t3_second_instr", bus.out_instr, 32'h00112023);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // illegal words, stream continues
    cyc(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    chk("t4_ones_illegal", {31'b0, bus.out_illegal}, 32'd1);
    chk("t4_ones_code", {22'b0, bus.out_code}, 32'd0);
    cyc(1'b1, 32'h0000000F, 1'b1, 1'b0);
    chk("t4_fence_illegal", {31'b0, bus.out_illegal}, 32'd1);
    chk("t4_fence_code", {22'b0, bus.out_code}, 32'd0);
    cyc(1'b1, 32'h00000073, 1'b1, 1'b0);
    chk("t4_after_code", {22'b0, bus.out_code}, 32'b1000000000);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // flush in full state with a word offered
    cyc(1'b1, 32'h00000063, 1'b0, 1'b0);
    cyc(1'b1, 32'h00000017, 1'b0, 1'b0);
    cyc(1'b1, 32'h00000037, 1'b0, 1'b1);
    chk("t5_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("t5_in_ready", {31'b0, bus.in_ready}, 32'd1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t5_dropped", {31'b0, bus.out_valid}, 32'd0);

    // async reset while stalled
    cyc(1'b1, 32'h00000067, 1'b0, 1'b0);
    cyc(1'b1, 32'h00208033, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("t6_out_code", {22'b0, bus.out_code}, 32'd0);
    chk("t6_out_instr", bus.out_instr, 32'd0);
    chk("t6_out_illegal", {31'b0, bus.out_illegal}, 32'd0);
    chk("t6_in_ready", {31'b0, bus.in_ready}, 32'd1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 32'h00002083, 1'b1, 1'b0);
    chk("t6_after_code", {22'b0, bus.out_code}, 32'b0100000000);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      rnd = $urandom;
      if ($urandom_range(0, 3) != 0) word = {rnd[31:7], opc_tab[$urandom_range(0, 9)]};
      else word = rnd;
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 2) != 0);
      rf = ($urandom_range(0, 40) == 0);
      cyc(rv, word, rr, rf);
    end
    repeat (3) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
